// File: rtl/counter_pkg.sv
// Shared types and limits for the up/down counter family.
package counter_pkg;

    // Counting direction as seen on the up_down pin.
    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

    // Boundary behaviour as seen on the saturate pin.
    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Widest counter this family is meant to be built at.
    localparam int CNT_MAX_WIDTH = 16;

endpackage

// File: rtl/counter_next_logic.sv
// Combinational step logic: the count one enabled step ahead, plus a flag marking
// a boundary event (stepping past max_value going up, or past zero going down).
module counter_next_logic
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] max_value,
    input  logic             up_down,
    input  logic             saturate,
    output logic [WIDTH-1:0] next_count,
    output logic             boundary
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    cnt_dir_e         dir;
    cnt_mode_e        mode;
    logic             at_or_above_max;
    logic             above_max;
    logic             at_zero;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;

    assign dir             = cnt_dir_e'(up_down);
    assign mode            = cnt_mode_e'(saturate);
    assign at_or_above_max = (count >= max_value);
    assign above_max       = (count > max_value);
    assign at_zero         = (count == '0);
    assign count_inc       = count + ONE;
    assign count_dec       = count - ONE;

    // Choose the stepped value; a count left above a lowered max_value is pulled
    // back to max_value when saturating down, but that is not a boundary event.
    always_comb begin
        next_count = count;
        boundary   = 1'b0;
        if (dir == CNT_UP) begin
            if (at_or_above_max) begin
                boundary   = 1'b1;
                next_count = (mode == CNT_SAT) ? max_value : '0;
            end else begin
                next_count = count_inc;
            end
        end else begin
            if (at_zero) begin
                boundary   = 1'b1;
                next_count = (mode == CNT_SAT) ? '0 : max_value;
            end else if (above_max && (mode == CNT_SAT)) begin
                next_count = max_value;
            end else begin
                next_count = count_dec;
            end
        end
    end

endmodule

// File: rtl/d_flipflop.sv
// Single-bit D flip-flop with asynchronous active-low reset to a fixed bit value.
module d_flipflop #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    // Capture d on each rising edge; reset_n forces the configured reset bit at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= RESET_BIT;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/counter_updown_n.sv
// Parametrised up/down counter with clear, clamped load, wrap/saturate modes,
// a registered terminal-count pulse and a sticky overflow flag.
module counter_updown_n
    import counter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             enable,
    input  logic             up_down,
    input  logic             saturate,
    input  logic [WIDTH-1:0] max_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] step_count;
    logic             step_boundary;
    logic [WIDTH-1:0] load_count;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic             overflow_d;

    counter_next_logic #(
        .WIDTH(WIDTH)
    ) u_next (
        .count      (count),
        .max_value  (max_value),
        .up_down    (up_down),
        .saturate   (saturate),
        .next_count (step_count),
        .boundary   (step_boundary)
    );

    // Loaded values never exceed the programmed terminal value.
    assign load_count = (load_data < max_value) ? load_data : max_value;

    // Priority mux: clear beats load beats enable beats hold; tc only survives one cycle.
    always_comb begin
        count_d    = count;
        tc_d       = 1'b0;
        overflow_d = overflow;
        if (clear) begin
            count_d    = RESET_COUNT;
            overflow_d = 1'b0;
        end else if (load) begin
            count_d = load_count;
        end else if (enable) begin
            count_d    = step_count;
            tc_d       = step_boundary;
            overflow_d = overflow | step_boundary;
        end
    end

    // One flip-flop per count bit, each resetting to its bit of RESET_VALUE.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_count_bit
            d_flipflop #(
                .RESET_BIT(RESET_COUNT[i])
            ) u_bit (
                .clk     (clk),
                .reset_n (reset_n),
                .d       (count_d[i]),
                .q       (count[i])
            );
        end
    endgenerate

    // Status flags register alongside the count so tc lines up with the new value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tc       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            tc       <= tc_d;
            overflow <= overflow_d;
        end
    end

endmodule

// File: tb/tb_counter_updown_n.sv
// Self-checking bench for counter_updown_n: a 4-bit instance (RESET_VALUE 3) and an
// 8-bit instance (RESET_VALUE 0) checked against an integer reference model.
module tb_counter_updown_n;

    localparam int AW  = 4;
    localparam int ARV = 3;
    localparam int BW  = 8;
    localparam int BRV = 0;

    logic clk = 1'b0;
    logic reset_n;

    logic          a_clear, a_load, a_enable, a_up_down, a_saturate;
    logic [AW-1:0] a_load_data, a_max_value, a_count;
    logic          a_tc, a_overflow;

    logic          b_clear, b_load, b_enable, b_up_down, b_saturate;
    logic [BW-1:0] b_load_data, b_max_value, b_count;
    logic          b_tc, b_overflow;

    int m_a_count, m_b_count;
    bit m_a_tc, m_a_ov, m_b_tc, m_b_ov;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    counter_updown_n #(.WIDTH(AW), .RESET_VALUE(ARV)) dut_a (
        .clk(clk), .reset_n(reset_n), .clear(a_clear), .load(a_load),
        .load_data(a_load_data), .enable(a_enable), .up_down(a_up_down),
        .saturate(a_saturate), .max_value(a_max_value), .count(a_count),
        .tc(a_tc), .overflow(a_overflow)
    );

    counter_updown_n #(.WIDTH(BW), .RESET_VALUE(BRV)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(b_clear), .load(b_load),
        .load_data(b_load_data), .enable(b_enable), .up_down(b_up_down),
        .saturate(b_saturate), .max_value(b_max_value), .count(b_count),
        .tc(b_tc), .overflow(b_overflow)
    );

    // Reference model: one clock edge of the counter, written straight from the rules.
    function automatic void model_step(input bit clr, input bit ld, input int ld_data,
                                       input bit en, input bit up, input bit sat,
                                       input int mx, input int rv,
                                       inout int c, inout bit t, inout bit o);
        t = 1'b0;
        if (clr) begin
            c = rv;
            o = 1'b0;
        end else if (ld) begin
            c = (ld_data < mx) ? ld_data : mx;
        end else if (en) begin
            if (up) begin
                if (c < mx) begin
                    c = c + 1;
                end else begin
                    t = 1'b1;
                    o = 1'b1;
                    c = sat ? mx : 0;
                end
            end else begin
                if (c == 0) begin
                    t = 1'b1;
                    o = 1'b1;
                    c = sat ? 0 : mx;
                end else if (sat && (c > mx)) begin
                    c = mx;
                end else begin
                    c = c - 1;
                end
            end
        end
    endfunction

    // Advance both models by the inputs now applied, then let the DUTs take the edge.
    task automatic tick();
        model_step(a_clear, a_load, int'(a_load_data), a_enable, a_up_down, a_saturate,
                   int'(a_max_value), ARV, m_a_count, m_a_tc, m_a_ov);
        model_step(b_clear, b_load, int'(b_load_data), b_enable, b_up_down, b_saturate,
                   int'(b_max_value), BRV, m_b_count, m_b_tc, m_b_ov);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_clear = 0; a_load = 0; a_enable = 0; a_up_down = 1; a_saturate = 0;
        a_load_data = '0; a_max_value = 4'd9;
        b_clear = 0; b_load = 0; b_enable = 0; b_up_down = 1; b_saturate = 0;
        b_load_data = '0; b_max_value = 8'd255;
    endtask

    task automatic model_reset();
        m_a_count = ARV; m_a_tc = 0; m_a_ov = 0;
        m_b_count = BRV; m_b_tc = 0; m_b_ov = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (a_count !== 4'd3) begin
            tests_failed++;
            $display("[TB] FAIL reset_count_a: got %0d expected 3", a_count);
        end
        tests_run++;
        if (a_tc !== 1'b0 || a_overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags_a: got tc=%b ov=%b expected 0 0", a_tc, a_overflow);
        end
        tests_run++;
        if (b_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_count_b: got %0d expected 0", b_count);
        end
        reset_n = 1'b1;
        // Step 3 -> boundary with max 3, so flags are set before the async reset.
        a_max_value = 4'd3; a_enable = 1; a_up_down = 1; a_saturate = 0;
        tick();
        tests_run++;
        if (a_count !== 4'd0 || a_tc !== 1'b1 || a_overflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_wrap: got c=%0d tc=%b ov=%b expected c=0 tc=1 ov=1",
                     a_count, a_tc, a_overflow);
        end
        a_enable = 0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (a_count !== 4'd3 || a_tc !== 1'b0 || a_overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got c=%0d tc=%b ov=%b expected c=3 tc=0 ov=0",
                     a_count, a_tc, a_overflow);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_up_wrap();
        a_max_value = 4'd9; a_load = 1; a_load_data = 4'd0; a_enable = 0;
        tick();
        a_load = 0; a_enable = 1; a_up_down = 1; a_saturate = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            tests_run++;
            if (a_count !== AW'(i % 10) || a_tc !== (i == 10)) begin
                tests_failed++;
                $display("[TB] FAIL up_wrap step %0d: got c=%0d tc=%b expected c=%0d tc=%b",
                         i, a_count, a_tc, i % 10, (i == 10));
            end
            tests_run++;
            if (a_overflow !== (i >= 10)) begin
                tests_failed++;
                $display("[TB] FAIL up_wrap_overflow step %0d: got %b expected %b",
                         i, a_overflow, (i >= 10));
            end
        end
    endtask

    task automatic test_down_sat();
        int exp_c[4] = '{1, 0, 0, 0};
        bit exp_t[4] = '{0, 0, 1, 1};
        a_enable = 0; a_load = 1; a_load_data = 4'd2; a_max_value = 4'd9;
        tick();
        a_load = 0; a_enable = 1; a_up_down = 0; a_saturate = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (a_count !== AW'(exp_c[i]) || a_tc !== exp_t[i]) begin
                tests_failed++;
                $display("[TB] FAIL down_sat cycle %0d: got c=%0d tc=%b expected c=%0d tc=%b",
                         i + 1, a_count, a_tc, exp_c[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_priority();
        a_clear = 1; a_load = 1; a_enable = 1; a_load_data = 4'd7; a_max_value = 4'd9;
        tick();
        tests_run++;
        if (a_count !== 4'd3 || a_overflow !== 1'b0 || a_tc !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL clear_priority: got c=%0d tc=%b ov=%b expected c=3 tc=0 ov=0",
                     a_count, a_tc, a_overflow);
        end
        a_clear = 0; a_load_data = 4'd12;
        tick();
        tests_run++;
        if (a_count !== 4'd9 || a_tc !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_clamp: got c=%0d tc=%b expected c=9 tc=0", a_count, a_tc);
        end
        a_load = 0; a_enable = 0;
    endtask

    task automatic test_max_lowered();
        for (int mode = 0; mode < 2; mode++) begin
            for (int dir = 1; dir >= 0; dir--) begin
                int exp_c;
                bit exp_t;
                exp_c = (dir == 1) ? ((mode == 1) ? 5 : 0) : ((mode == 1) ? 5 : 7);
                exp_t = (dir == 1);
                a_enable = 0; a_load = 1; a_load_data = 4'd8; a_max_value = 4'd15;
                tick();
                a_load = 0; a_max_value = 4'd5; a_enable = 1;
                a_up_down = dir[0]; a_saturate = mode[0];
                tick();
                tests_run++;
                if (a_count !== AW'(exp_c) || a_tc !== exp_t) begin
                    tests_failed++;
                    $display("[TB] FAIL max_lowered sat=%0d up=%0d: got c=%0d tc=%b expected c=%0d tc=%b",
                             mode, dir, a_count, a_tc, exp_c, exp_t);
                end
            end
        end
        a_enable = 0;
    endtask

    task automatic test_zero_max();
        a_max_value = 4'd0; a_load = 1; a_load_data = 4'd6; a_enable = 0;
        tick();
        tests_run++;
        if (a_count !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL zero_max_load: got %0d expected 0", a_count);
        end
        a_load = 0; a_enable = 1; a_up_down = 1; a_saturate = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (a_count !== 4'd0 || a_tc !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL zero_max cycle %0d: got c=%0d tc=%b expected c=0 tc=1",
                         i + 1, a_count, a_tc);
            end
        end
    endtask

    task automatic test_hold();
        a_enable = 0;
        tick();
        tests_run++;
        if (a_count !== 4'd0 || a_tc !== 1'b0 || a_overflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL hold: got c=%0d tc=%b ov=%b expected c=0 tc=0 ov=1",
                     a_count, a_tc, a_overflow);
        end
    endtask

    task automatic test_wide();
        b_max_value = 8'd255; b_load = 1; b_load_data = 8'd254; b_enable = 0;
        tick();
        b_load = 0; b_enable = 1; b_up_down = 1; b_saturate = 0;
        tick();
        tests_run++;
        if (b_count !== 8'd255 || b_tc !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wide_top: got c=%0d tc=%b expected c=255 tc=0", b_count, b_tc);
        end
        tick();
        tests_run++;
        if (b_count !== 8'd0 || b_tc !== 1'b1 || b_overflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wide_wrap: got c=%0d tc=%b ov=%b expected c=0 tc=1 ov=1",
                     b_count, b_tc, b_overflow);
        end
        b_enable = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            a_clear     = ($urandom_range(0, 31) == 0);
            a_load      = ($urandom_range(0, 7) == 0);
            a_load_data = AW'($urandom);
            a_enable    = ($urandom_range(0, 3) != 0);
            a_up_down   = 1'($urandom);
            a_saturate  = 1'($urandom);
            if ($urandom_range(0, 15) == 0)
                a_max_value = ($urandom_range(0, 3) == 0) ? 4'd0 : AW'($urandom);
            b_clear     = ($urandom_range(0, 31) == 0);
            b_load      = ($urandom_range(0, 7) == 0);
            b_load_data = BW'($urandom);
            b_enable    = ($urandom_range(0, 3) != 0);
            b_up_down   = 1'($urandom);
            b_saturate  = 1'($urandom);
            if ($urandom_range(0, 15) == 0)
                b_max_value = ($urandom_range(0, 3) == 0) ? 8'd3 : BW'($urandom);
            tick();
            tests_run++;
            if (a_count !== AW'(m_a_count) || a_tc !== m_a_tc || a_overflow !== m_a_ov) begin
                tests_failed++;
                $display("[TB] FAIL random_a cycle %0d: got c=%0d tc=%b ov=%b expected c=%0d tc=%b ov=%b",
                         i, a_count, a_tc, a_overflow, m_a_count, m_a_tc, m_a_ov);
            end
            tests_run++;
            if (b_count !== BW'(m_b_count) || b_tc !== m_b_tc || b_overflow !== m_b_ov) begin
                tests_failed++;
                $display("[TB] FAIL random_b cycle %0d: got c=%0d tc=%b ov=%b expected c=%0d tc=%b ov=%b",
                         i, b_count, b_tc, b_overflow, m_b_count, m_b_tc, m_b_ov);
            end
        end
        idle_inputs();
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_priority();
        test_max_lowered();
        test_zero_max();
        test_hold();
        test_wide();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
